// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the fetch/LSU requesters and the
// unified memory. The arbiter uses the slave modport; its environment uses master.
//
// Handshake: a requester raises x_req with x_addr (and d_we/d_wdata) stable and
// holds them until the one-cycle x_done pulse, dropping or replacing the request
// on the edge that samples done. The arbiter holds mem_req and every mem_* output
// stable until it samples mem_ack high; mem_ack is ignored while mem_req is low.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store traffic onto one single-ported memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           state_o,
  output logic                 owner_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            winner;
  logic              any_req;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t            last_owner_q, last_owner_d;
`endif

  assign any_req = bus.i_req | bus.d_req;

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.i_req && bus.d_req) begin
      winner = (last_owner_q == OWN_D) ? OWN_I : OWN_D;
    end else begin
      winner = bus.d_req ? OWN_D : OWN_I;
    end
`else
    winner = bus.d_req ? OWN_D : OWN_I;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: if (bus.mem_ack) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d   = winner;
          mem_req_d = 1'b1;
          if (winner == OWN_D) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_owner_d = winner;
`endif
        end
      end
      S_ISSUE: begin
        // Address/data stay put; only the ack retires the access.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_I) begin
            i_rdata_d = bus.mem_rdata;
            i_done_d  = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = bus.mem_rdata;
            d_done_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to D so the first tie after reset goes to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_D;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;

  assign state_o = state_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// run scored against a transaction-level model of arbitration and memory.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NUM_RAND = 150;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] state_o;
  logic owner_o;
  int n_vec = 0;
  int n_err = 0;

  logic mem_auto = 1'b1;
  logic ack_auto = 1'b0;
  logic ack_man = 1'b0;
  logic [DW-1:0] rdata_auto = '0;
  logic [DW-1:0] rdata_man = '0;
  int ack_wait = 0;
  int wait_cnt = 0;
  bit rand_wait = 1'b0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [0:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_o(state_o),
    .owner_o(owner_o)
  );

  assign bus.mem_ack   = mem_auto ? ack_auto : ack_man;
  assign bus.mem_rdata = mem_auto ? rdata_auto : rdata_man;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return ~a;
  endfunction

  // Memory model: acks after ack_wait idle cycles of mem_req, reads/writes mem.
  always @(posedge clk) begin
    #1;
    ack_auto = 1'b0;
    if (bus.mem_req === 1'b1) begin
      if (wait_cnt >= ack_wait) begin
        ack_auto = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          rdata_auto = $urandom;
        end else begin
          rdata_auto = mem_rd(bus.mem_addr);
        end
        wait_cnt = 0;
        if (rand_wait) ack_wait = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    mem_auto = 1'b1;
    ack_man = 1'b0;
    rdata_man = '0;
    ack_wait = 0;
    rand_wait = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    mem.delete();
    ref_mem.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.mem_req, bus.mem_we, bus.i_done, bus.d_done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.mem_req, bus.mem_we, bus.i_done, bus.d_done});
    end
    n_vec++;
    if (bus.mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    n_vec++;
    if (bus.mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
    n_vec++;
    if (bus.i_rdata !== '0) begin n_err++; $display("FAIL reset_i_rdata: got %h expected 0", bus.i_rdata); end
    n_vec++;
    if (bus.d_rdata !== '0) begin n_err++; $display("FAIL reset_d_rdata: got %h expected 0", bus.d_rdata); end
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_req: got %b expected 0", bus.mem_req); end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    mem[32'h10] = 32'h0000_0013;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h10;
    tick();
    n_vec++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_issue: got req=%b we=%b addr=%h done=%b expected 1 0 00000010 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done);
    end
    tick();
    n_vec++;
    if ({bus.i_done, bus.d_done, bus.i_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
      n_err++;
      $display("FAIL fetch_done: got i_done=%b d_done=%b i_rdata=%h expected 1 0 00000013",
               bus.i_done, bus.d_done, bus.i_rdata);
    end
    bus.i_req = 1'b0;
    tick();
    n_vec++;
    if ({bus.i_done, bus.mem_req} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_after: got i_done=%b mem_req=%b expected 0 0", bus.i_done, bus.mem_req);
    end
  endtask

  task automatic test_store_load();
    apply_reset();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000040 deadbeef",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_vec++;
    if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL store_done: got d_done=%b d_rdata=%h expected 1 00000000", bus.d_done, bus.d_rdata);
    end
    bus.d_we = 1'b0;
    bus.d_wdata = 32'h0;
    tick();
    tick();
    n_vec++;
    if ({bus.mem_req, bus.mem_we} !== 2'b10) begin
      n_err++;
      $display("FAIL load_issue: got req=%b we=%b expected 1 0", bus.mem_req, bus.mem_we);
    end
    tick();
    n_vec++;
    if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL load_done: got d_done=%b d_rdata=%h expected 1 deadbeef", bus.d_done, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    apply_reset();
    ack_wait = 3;
    mem[32'h80] = 32'hCAFE_0080;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h80;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        n_vec++;
        if ({bus.mem_req, bus.mem_addr, bus.i_done} !== {1'b1, 32'h80, 1'b0}) begin
          n_err++;
          $display("FAIL wait_hold c%0d: got req=%b addr=%h done=%b expected 1 00000080 0",
                   c, bus.mem_req, bus.mem_addr, bus.i_done);
        end
      end else begin
        n_vec++;
        if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'hCAFE_0080}) begin
          n_err++;
          $display("FAIL wait_done: got done=%b rdata=%h expected 1 cafe0080", bus.i_done, bus.i_rdata);
        end
      end
    end
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int got;
    logic [0:0] e;
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(RR ? 1'(k % 2) : 1'b1);
    bus.i_req = 1'b1;
    bus.i_addr = 32'h100;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h200;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      n_vec++;
      if (bus.i_done && bus.d_done) begin n_err++; $display("FAIL contend_overlap: got both dones expected one"); end
      if (bus.i_done || bus.d_done) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.d_done !== e) begin
          n_err++;
          $display("FAIL contend_grant%0d: got d_done=%b expected %b", got, bus.d_done, e);
        end
        got++;
      end
    end
    n_vec++;
    if (got != 4) begin n_err++; $display("FAIL contend_count: got %0d expected 4", got); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    mem[32'h20] = 32'h1111_2222;
    mem[32'h30] = 32'h3030_3030;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h20;
    tick();
    tick();
    n_vec++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h1111_2222}) begin
      n_err++;
      $display("FAIL pre_reset_fetch: got done=%b rdata=%h expected 1 11112222", bus.i_done, bus.i_rdata);
    end
    bus.i_addr = 32'h24;
    mem_auto = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL stuck_issue: got %b expected 1", bus.mem_req); end
    tick();
    reset = 1'b1;
    bus.i_req = 1'b0;
    #1;
    n_vec++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata, bus.i_done, bus.d_done} !== '0) begin
      n_err++;
      $display("FAIL async_clear: got req=%b addr=%h i_rdata=%h expected all 0", bus.mem_req, bus.mem_addr, bus.i_rdata);
    end
    tick();
    reset = 1'b0;
    tick();
    ack_man = 1'b1;
    rdata_man = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      tick();
      ack_man = 1'b0;
      n_vec++;
      if ({bus.mem_req, bus.i_done, bus.d_done} !== 3'b000) begin
        n_err++;
        $display("FAIL late_ack c%0d: got req=%b i_done=%b d_done=%b expected 0 0 0", c, bus.mem_req, bus.i_done, bus.d_done);
      end
    end
    mem_auto = 1'b1;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h30;
    tick();
    n_vec++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h30}) begin
      n_err++;
      $display("FAIL restart_issue: got req=%b addr=%h expected 1 00000030", bus.mem_req, bus.mem_addr);
    end
    tick();
    n_vec++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h3030_3030}) begin
      n_err++;
      $display("FAIL restart_done: got done=%b rdata=%h expected 1 30303030", bus.i_done, bus.i_rdata);
    end
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int t[$];
    apply_reset();
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0;
    for (int c = 0; c < 30 && t.size() < 4; c++) begin
      tick();
      n_vec++;
      if (bus.d_done !== 1'b0) begin n_err++; $display("FAIL b2b_d_done: got %b expected 0", bus.d_done); end
      if (bus.i_done === 1'b1) begin
        t.push_back(c);
        bus.i_addr = bus.i_addr + 32'h4;
      end
    end
    n_vec++;
    if (t.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected 4", t.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_vec++;
        if (t[k] - t[k-1] != 3) begin
          n_err++;
          $display("FAIL b2b_spacing%0d: got %0d expected 3", k, t[k] - t[k-1]);
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] i_a, d_a, exp_a;
    logic [DW-1:0] d_w, d_hold, exp_d, exp_wd;
    logic d_st, exp_we;
    bit i_pend, d_pend, cur_d, last_d, win_d, any;
    bit idle_prev, idle_now, done_last, done_now, ack_seen;
    int done_cnt;
    apply_reset();
    rand_wait = 1'b1;
    ack_wait = $urandom_range(0, 3);
    i_a = '0; d_a = '0; d_w = '0; d_st = 1'b0; d_hold = '0;
    i_pend = 0; d_pend = 0; cur_d = 0; last_d = 1;
    idle_prev = 1; done_last = 0; ack_seen = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 4000 && done_cnt < NUM_RAND; cyc++) begin
      tick();
      any = 0;
      if (idle_prev) begin
        any = bus.i_req || bus.d_req;
        n_vec++;
        if (bus.mem_req !== any) begin
          n_err++;
          $display("FAIL rand_issue_timing cyc%0d: got mem_req=%b expected %b", cyc, bus.mem_req, any);
        end
        if (any) begin
          if (bus.i_req && bus.d_req) win_d = RR ? !last_d : 1'b1;
          else win_d = bus.d_req;
          last_d = win_d;
          cur_d = win_d;
          exp_a  = win_d ? d_a : i_a;
          exp_we = win_d ? d_st : 1'b0;
          exp_wd = win_d ? d_w : '0;
          n_vec++;
          if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {exp_we, exp_a, exp_wd}) begin
            n_err++;
            $display("FAIL rand_issue cyc%0d: got we=%b addr=%h wdata=%h expected %b %h %h",
                     cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, exp_a, exp_wd);
          end
        end
      end
      done_now = ack_seen;
      n_vec++;
      if ({bus.i_done, bus.d_done} !== {done_now && !cur_d, done_now && cur_d}) begin
        n_err++;
        $display("FAIL rand_done cyc%0d: got i=%b d=%b expected %b %b",
                 cyc, bus.i_done, bus.d_done, done_now && !cur_d, done_now && cur_d);
      end
      if (done_now && !cur_d) begin
        exp_d = ref_rd(i_a);
        n_vec++;
        if (bus.i_rdata !== exp_d) begin
          n_err++;
          $display("FAIL rand_i_rdata cyc%0d: got %h expected %h", cyc, bus.i_rdata, exp_d);
        end
        i_pend = 0;
        bus.i_req = 1'b0;
        done_cnt++;
      end
      if (done_now && cur_d) begin
        if (d_st) begin
          ref_mem[d_a] = d_w;
        end else begin
          d_hold = ref_rd(d_a);
        end
        n_vec++;
        if (bus.d_rdata !== d_hold) begin
          n_err++;
          $display("FAIL rand_d_rdata cyc%0d: got %h expected %h (store=%b)", cyc, bus.d_rdata, d_hold, d_st);
        end
        d_pend = 0;
        bus.d_req = 1'b0;
        done_cnt++;
      end
      idle_now = done_last || (idle_prev && !any);
      done_last = done_now;
      ack_seen = (ack_auto === 1'b1) && (bus.mem_req === 1'b1);
      idle_prev = idle_now;
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1;
        i_a = AW'($urandom_range(0, 15) * 4);
        bus.i_req = 1'b1;
        bus.i_addr = i_a;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1;
        d_a = AW'($urandom_range(0, 15) * 4);
        d_st = 1'($urandom_range(0, 1));
        d_w = $urandom;
        bus.d_req = 1'b1;
        bus.d_we = d_st;
        bus.d_addr = d_a;
        bus.d_wdata = d_w;
      end
    end
    n_vec++;
    if (done_cnt < NUM_RAND) begin
      n_err++;
      $display("FAIL rand_budget: got %0d completions expected %0d", done_cnt, NUM_RAND);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_wait_states();
    test_contention();
    test_reset_mid_issue();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
